// File: rtl/dwa_sel_seq18.sv
// dwa_sel_seq18: DWA selection sequencer for an 18-element unary DAC.
// Each accepted code N makes the block emit N consecutive element addresses,
// one per clock, starting at a pointer that rotates modulo 18 (DWA mode) or
// at 0 (static mode). Frames chain with no gap when codes arrive back-to-back.
module dwa_sel_seq18 #(
  parameter int NELEM = 18,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] code_in,
  input  logic          code_valid,
  output logic          code_ready,
  input  logic          dem_en,
  output logic [AW-1:0] sel_addr,
  output logic          sel_en,
  output logic          frame_done,
  output logic          clip,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] NMAX = AW'(NELEM);
  localparam logic [AW-1:0] LAST = AW'(NELEM - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [AW-1:0] sel_addr_q, sel_addr_d;
  logic          sel_en_q, sel_en_d;
  logic          frame_done_q, frame_done_d;
  logic          clip_q, clip_d;

  logic          accept;
  logic [AW-1:0] n_code;
  logic [AW-1:0] p_start;
  logic [AW-1:0] p_next;
  logic [AW-1:0] ptr_next;

  // Modulo-18 increment of an element address.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] x);
    return (x == LAST) ? '0 : x + AW'(1);
  endfunction

  // Acceptance handshake, clipped code and frame start address.
  always_comb begin
    code_ready = (state_q == IDLE) || (rem_q == AW'(1));
    accept     = code_valid && code_ready;
    n_code     = (code_in > NMAX) ? NMAX : code_in;
    p_start    = dem_en ? ptr_q : '0;
    p_next     = wrap_inc(p_start);
    ptr_next   = wrap_inc(ptr_q);
  end

  // Next-state and output-register logic; pulses default low, addresses hold.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    sel_addr_d   = sel_addr_q;
    sel_en_d     = 1'b0;
    frame_done_d = 1'b0;
    clip_d       = 1'b0;
    if (accept) begin
      clip_d = (code_in > NMAX);
      if (n_code != '0) begin
        sel_addr_d   = p_start;
        sel_en_d     = 1'b1;
        ptr_d        = p_next;
        rem_d        = n_code;
        state_d      = RUN;
        frame_done_d = (n_code == AW'(1));
      end else begin
        // Empty frame: a lone frame_done pulse, pointer only reset in static mode.
        frame_done_d = 1'b1;
        ptr_d        = p_start;
        rem_d        = '0;
        state_d      = IDLE;
      end
    end else if (state_q == RUN) begin
      if (rem_q > AW'(1)) begin
        sel_addr_d   = ptr_q;
        sel_en_d     = 1'b1;
        ptr_d        = ptr_next;
        rem_d        = rem_q - AW'(1);
        frame_done_d = (rem_q == AW'(2));
      end else begin
        rem_d   = '0;
        state_d = IDLE;
      end
    end
  end

  // State and output registers; reset discards any partial frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      rem_q        <= '0;
      sel_addr_q   <= '0;
      sel_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      clip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      sel_addr_q   <= sel_addr_d;
      sel_en_q     <= sel_en_d;
      frame_done_q <= frame_done_d;
      clip_q       <= clip_d;
    end
  end

  assign sel_addr   = sel_addr_q;
  assign sel_en     = sel_en_q;
  assign frame_done = frame_done_q;
  assign clip       = clip_q;
  assign ptr        = ptr_q;

endmodule
